// File: rtl/trng_sampler_if.sv
// Random-word output port of trng_sampler: data, valid and ready.
interface trng_sampler_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/trng_sampler.sv
// Ring-oscillator TRNG sampler: synchronise, XOR-combine, optional von-Neumann
// debias, pack into words, with a repetition-count health test gating output.
module trng_sampler #(
  parameter int N_CH      = 4,
  parameter int WIDTH     = 8,
  parameter int DIV_W     = 8,
  parameter int RCT_LIMIT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   ro_in,
  input  logic [N_CH-1:0]   ch_mask,
  input  logic              en,
  input  logic              vn_en,
  input  logic [DIV_W-1:0]  div,
  trng_sampler_if.master    out_if,
  output logic              overflow,
  output logic              health_fail,
  input  logic              health_clr
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int REP_W = $clog2(RCT_LIMIT + 1);

  typedef enum logic [0:0] {VN_EMPTY, VN_HALF} vn_state_t;

  logic [N_CH-1:0]  sync1_q, sync1_d;
  logic [N_CH-1:0]  sync2_q, sync2_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  vn_state_t        vn_state_q, vn_state_d;
  logic             vn_p_q, vn_p_d;
  logic             vn_en_q, vn_en_d;
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             prev_c_q, prev_c_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             hf_q, hf_d;

  logic             c;
  logic             tick;
  logic             bit_vld;
  logic             bit_val;
  vn_state_t        vn_state_eff;
  logic [WIDTH-1:0] word;
  logic             word_done;
  logic             handshake;

  always_comb begin
    sync1_d = ro_in;
    sync2_d = sync1_q;
    c       = ^(sync2_q & ch_mask);

    // >= rather than == so a div lowered mid-count wraps immediately
    tick      = en && (div_cnt_q >= div);
    div_cnt_d = (!en || tick) ? '0 : div_cnt_q + DIV_W'(1);

    vn_en_d      = vn_en;
    vn_state_eff = (vn_en ^ vn_en_q) ? VN_EMPTY : vn_state_q;
    vn_state_d   = vn_state_eff;
    vn_p_d       = vn_p_q;
    bit_vld      = 1'b0;
    bit_val      = c;
    if (!en) begin
      vn_state_d = VN_EMPTY;
    end else if (tick) begin
      if (!vn_en) begin
        bit_vld = 1'b1;
      end else begin
        unique case (vn_state_eff)
          VN_EMPTY: begin
            vn_p_d     = c;
            vn_state_d = VN_HALF;
          end
          VN_HALF: begin
            vn_state_d = VN_EMPTY;
            if (c != vn_p_q) begin
              bit_vld = 1'b1;
              bit_val = vn_p_q;
            end
          end
          default: vn_state_d = VN_EMPTY;
        endcase
      end
    end

    word      = {sr_q, bit_val};
    sr_d      = sr_q;
    cnt_d     = en ? cnt_q : '0;
    word_done = 1'b0;
    if (bit_vld) begin
      sr_d = word[WIDTH-2:0];
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        cnt_d     = '0;
        word_done = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    handshake = valid_q && out_if.out_ready;
    valid_d   = valid_q && !handshake;
    data_d    = data_q;
    ovf_d     = ovf_q;
    if (word_done && !hf_q) begin
      if (!valid_q || handshake) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    prev_c_d = prev_c_q;
    rep_d    = rep_q;
    hf_d     = hf_q;
    if (tick) begin
      prev_c_d = c;
      // rep == 0 means no previous sample since reset/clear
      if (rep_q != '0 && c == prev_c_q) begin
        rep_d = (rep_q == REP_W'(RCT_LIMIT)) ? rep_q : rep_q + REP_W'(1);
      end else begin
        rep_d = REP_W'(1);
      end
      if (rep_d == REP_W'(RCT_LIMIT)) hf_d = 1'b1;
    end
    if (health_clr) begin
      hf_d  = 1'b0;
      rep_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      div_cnt_q  <= '0;
      vn_state_q <= VN_EMPTY;
      vn_p_q     <= 1'b0;
      vn_en_q    <= 1'b0;
      sr_q       <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      prev_c_q   <= 1'b0;
      rep_q      <= '0;
      hf_q       <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      div_cnt_q  <= div_cnt_d;
      vn_state_q <= vn_state_d;
      vn_p_q     <= vn_p_d;
      vn_en_q    <= vn_en_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      prev_c_q   <= prev_c_d;
      rep_q      <= rep_d;
      hf_q       <= hf_d;
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign overflow         = ovf_q;
  assign health_fail      = hf_q;

endmodule

// File: tb/tb_trng_sampler.sv
// Directed bench for trng_sampler: sync latency, VN debias, overflow, health test,
// divider and mid-word reset, with hand-computed expected words.
module tb_trng_sampler;

  localparam int N_CH      = 4;
  localparam int WIDTH     = 8;
  localparam int DIV_W     = 8;
  localparam int RCT_LIMIT = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_CH-1:0]  ro_in;
  logic [N_CH-1:0]  ch_mask;
  logic             en;
  logic             vn_en;
  logic [DIV_W-1:0] div;
  logic             overflow;
  logic             health_fail;
  logic             health_clr;

  int errors = 0;
  int checks = 0;

  trng_sampler_if #(.WIDTH(WIDTH)) out_if ();

  trng_sampler #(
    .N_CH(N_CH),
    .WIDTH(WIDTH),
    .DIV_W(DIV_W),
    .RCT_LIMIT(RCT_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ro_in(ro_in),
    .ch_mask(ch_mask),
    .en(en),
    .vn_en(vn_en),
    .div(div),
    .out_if(out_if),
    .overflow(overflow),
    .health_fail(health_fail),
    .health_clr(health_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives n bits (MSB first) on ro_in[0]; en opens two cycles later so each
  // enabled cycle sees exactly one of the bits through the synchroniser.
  task automatic run_bits(input logic [31:0] bits, input int n);
    for (int i = 0; i < n + 2; i++) begin
      ro_in = '0;
      if (i < n) ro_in[0] = bits[n - 1 - i];
      en = (i >= 2);
      step();
    end
    en = 1'b0;
  endtask

  // div=3: each bit held 4 cycles; flags any out_valid before the final tick.
  task automatic feed_div4(input logic [7:0] w, input int nbits, output logic early);
    early = 1'b0;
    for (int t = 0; t < 4 * nbits; t++) begin
      ro_in    = '0;
      ro_in[0] = w[7 - t / 4];
      en       = 1'b1;
      step();
      if (t < 4 * nbits - 1 && out_if.out_valid) early = 1'b1;
    end
    en = 1'b0;
  endtask

  initial begin
    logic seen;
    rst              = 1'b1;
    ro_in            = '0;
    ch_mask          = '0;
    en               = 1'b0;
    vn_en            = 1'b0;
    div              = '0;
    health_clr       = 1'b0;
    out_if.out_ready = 1'b0;

    // 1: reset and idle
    repeat (2) step();
    chk("rst_valid", out_if.out_valid, 0);
    chk("rst_data", out_if.out_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_hf", health_fail, 0);
    rst     = 1'b0;
    ch_mask = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      ro_in = ~ro_in;
      step();
    end
    chk("idle_valid", out_if.out_valid, 0);

    // 2: direct pass, single channel
    ch_mask = 4'b0001;
    run_bits(32'b1011_0010, 8);
    chk("direct_valid", out_if.out_valid, 1);
    chk("direct_data", out_if.out_data, 32'hB2);
    step();
    chk("direct_hold", out_if.out_data, 32'hB2);
    out_if.out_ready = 1'b1;
    step();
    out_if.out_ready = 1'b0;
    chk("direct_drain", out_if.out_valid, 0);

    // 3: von-Neumann pairs 10,01,11,00,10,10,01,01,10,01
    vn_en = 1'b1;
    step();
    run_bits(32'h9CA59, 20);
    chk("vn_valid", out_if.out_valid, 1);
    chk("vn_data", out_if.out_data, 32'hB2);
    out_if.out_ready = 1'b1;
    step();
    out_if.out_ready = 1'b0;
    vn_en = 1'b0;
    step();

    // 4: overflow with consumer stalled
    run_bits(32'h5A, 8);
    chk("ovf_w1_data", out_if.out_data, 32'h5A);
    chk("ovf_before", overflow, 0);
    run_bits(32'hC3, 8);
    chk("ovf_held_data", out_if.out_data, 32'h5A);
    chk("ovf_held_valid", out_if.out_valid, 1);
    chk("ovf_set", overflow, 1);
    out_if.out_ready = 1'b1;
    step();
    chk("ovf_drain", out_if.out_valid, 0);

    // 5: stuck source trips the repetition-count test
    ch_mask    = '0;
    health_clr = 1'b1;
    step();
    health_clr = 1'b0;
    chk("hc_pre", health_fail, 0);
    en = 1'b1;
    repeat (RCT_LIMIT - 1) step();
    chk("hc_not_yet", health_fail, 0);
    step();
    chk("hc_trip", health_fail, 1);
    chk("hc_last_word", out_if.out_valid, 1);
    seen = 1'b0;
    repeat (16) begin
      step();
      if (out_if.out_valid) seen = 1'b1;
    end
    chk("hc_gated", seen, 0);
    health_clr = 1'b1;
    step();
    health_clr = 1'b0;
    chk("hc_clear", health_fail, 0);
    repeat (RCT_LIMIT - 1) step();
    chk("hc_retrip_not_yet", health_fail, 0);
    step();
    chk("hc_retrip", health_fail, 1);
    en         = 1'b0;
    health_clr = 1'b1;
    step();
    health_clr       = 1'b0;
    out_if.out_ready = 1'b0;
    chk("hc_final_clear", health_fail, 0);
    chk("hc_ovf_sticky", overflow, 1);

    // 6: divider and mid-word reset
    ch_mask = 4'b0001;
    div     = 8'd3;
    feed_div4(8'hA7, 8, seen);
    chk("div_early", seen, 0);
    chk("div_valid", out_if.out_valid, 1);
    chk("div_data", out_if.out_data, 32'hA7);
    out_if.out_ready = 1'b1;
    step();
    out_if.out_ready = 1'b0;
    feed_div4(8'h5F, 5, seen);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_valid", out_if.out_valid, 0);
    chk("mrst_data", out_if.out_data, 0);
    chk("mrst_ovf", overflow, 0);
    feed_div4(8'h3C, 8, seen);
    chk("mrst_early", seen, 0);
    chk("mrst_valid2", out_if.out_valid, 1);
    chk("mrst_data2", out_if.out_data, 32'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
